// File: rtl/wash_run.sv
// Execution stage of the washing machine: charges the job price against the
// balance, then runs WASH -> RINSE -> SPIN on a one-second tick with lid/button pause.
module wash_run #(
  parameter int TICK_CYC = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bal_in,
  input  logic [1:0]  mode,
  input  logic [4:0]  weight,
  input  logic        lid_open,
  input  logic        pause_btn,
  output logic        busy,
  output logic        done,
  output logic        charge_err,
  output logic [11:0] bal_out,
  output logic [3:0]  n0,
  output logic [3:0]  n1,
  output logic [3:0]  n2,
  output logic [3:0]  n3,
  output logic [3:0]  n5,
  output logic [3:0]  n6,
  output logic [3:0]  n7,
  output logic [3:0]  n8,
  output logic [2:0]  st_light
);

  localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHARGE = 3'd1;
  localparam logic [2:0] S_WASH   = 3'd2;
  localparam logic [2:0] S_RINSE  = 3'd3;
  localparam logic [2:0] S_SPIN   = 3'd4;
  localparam logic [2:0] S_PAUSE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [3:0] D_MINUS = 4'd10;
  localparam logic [3:0] D_BLANK = 4'hb;

  function automatic logic [5:0] wash_secs(input logic [1:0] m, input logic [4:0] w);
    case (m)
      2'd0:    wash_secs = 6'd10 + {1'b0, w};
      2'd1:    wash_secs = 6'd20 + {1'b0, w};
      2'd2:    wash_secs = 6'd30 + {1'b0, w};
      default: wash_secs = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] rinse_secs(input logic [1:0] m);
    case (m)
      2'd0:    rinse_secs = 6'd5;
      2'd1:    rinse_secs = 6'd10;
      2'd2:    rinse_secs = 6'd15;
      default: rinse_secs = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] spin_secs(input logic [1:0] m);
    spin_secs = (m == 2'd0) ? 6'd5 : 6'd10;
  endfunction

  function automatic logic [5:0] base_price(input logic [1:0] m);
    case (m)
      2'd0:    base_price = 6'd5;
      2'd1:    base_price = 6'd8;
      2'd2:    base_price = 6'd12;
      default: base_price = 6'd3;
    endcase
  endfunction

  logic [2:0]    state, next_state, ret_state;
  logic          start_q;
  logic [1:0]    mode_q;
  logic [4:0]    weight_q, weight_clamped;
  logic [6:0]    total_rem, total_c;
  logic [5:0]    phase_rem, load_rem;
  logic [5:0]    wash_c, rinse_c, spin_c, price_c;
  logic [CW-1:0] tick_cnt;
  logic          can_pay, running, pause_req, tick;
  logic [11:0]   disp_mag;

  assign weight_clamped = (weight > 5'd20) ? 5'd20 : weight;
  assign wash_c  = wash_secs(mode_q, weight_q);
  assign rinse_c = rinse_secs(mode_q);
  assign spin_c  = spin_secs(mode_q);
  assign price_c = base_price(mode_q) + {1'b0, weight_q};
  assign total_c = {1'b0, wash_c} + {1'b0, rinse_c} + {1'b0, spin_c};
  assign can_pay = $signed(bal_in) >= $signed({6'd0, price_c});

  assign running   = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
  // A pause request swallows a coincident tick; the counter simply holds.
  assign pause_req = running && (lid_open || pause_btn);
  assign tick      = running && !pause_req && (tick_cnt == TICK_LAST);

  assign busy = running || (state == S_PAUSE);
  assign done = (state == S_DONE);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    load_rem   = 6'd0;
    case (state)
      S_IDLE: if (start && !start_q) next_state = S_CHARGE;
      S_CHARGE: begin
        if (!can_pay) begin
          next_state = S_IDLE;
        end else if (wash_c != 6'd0) begin
          next_state = S_WASH;
          load_rem   = wash_c;
        end else if (rinse_c != 6'd0) begin
          next_state = S_RINSE;
          load_rem   = rinse_c;
        end else begin
          next_state = S_SPIN;
          load_rem   = spin_c;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (pause_req) begin
          next_state = S_PAUSE;
        end else if (tick && phase_rem == 6'd1) begin
          if (state == S_WASH && rinse_c != 6'd0) begin
            next_state = S_RINSE;
            load_rem   = rinse_c;
          end else if (state != S_SPIN) begin
            next_state = S_SPIN;
            load_rem   = spin_c;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_PAUSE: if (pause_btn && !lid_open) next_state = ret_state;
      S_DONE:  if (lid_open) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 2'd0;
      weight_q   <= 5'd0;
      bal_out    <= 12'd0;
      charge_err <= 1'b0;
      total_rem  <= 7'd0;
      phase_rem  <= 6'd0;
      tick_cnt   <= '0;
      st_light   <= 3'b001;
    end else begin
      state      <= next_state;
      start_q    <= start;
      charge_err <= 1'b0;

      if (state == S_IDLE && next_state == S_CHARGE) begin
        mode_q   <= mode;
        weight_q <= weight_clamped;
      end

      if (state == S_CHARGE) begin
        if (can_pay) begin
          bal_out   <= bal_in - {6'd0, price_c};
          total_rem <= total_c;
          phase_rem <= load_rem;
          tick_cnt  <= '0;
        end else begin
          bal_out    <= bal_in;
          charge_err <= 1'b1;
        end
      end

      if (pause_req) begin
        ret_state <= state;
      end else if (running) begin
        // The sub-second counter free-runs across phase changes.
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          total_rem <= total_rem - 7'd1;
          phase_rem <= (phase_rem == 6'd1) ? load_rem : phase_rem - 6'd1;
        end
      end

      case (next_state)
        S_IDLE:           st_light <= 3'b001;
        S_WASH, S_RINSE:  st_light <= 3'b010;
        S_SPIN:           st_light <= 3'b100;
        S_PAUSE:          st_light <= 3'b111;
        S_DONE:           st_light <= 3'b000;
        default:          ;
      endcase
    end
  end

  // Right display: n0 is the sign slot, n1 units, n2 tens, n3 hundreds.
  always_comb begin
    disp_mag = {5'd0, total_rem};
    n0       = D_BLANK;
    if (state == S_IDLE) begin
      if (bal_out[11]) begin
        disp_mag = -bal_out;
        n0       = D_MINUS;
      end else begin
        disp_mag = bal_out;
      end
    end
    n1 = 4'(disp_mag % 12'd10);
    n2 = 4'((disp_mag / 12'd10) % 12'd10);
    n3 = 4'((disp_mag / 12'd100) % 12'd10);
    if (state != S_IDLE && n3 == 4'd0) n3 = D_BLANK;
  end

  always_comb begin
    n5 = D_BLANK;
    n6 = D_BLANK;
    n7 = D_BLANK;
    n8 = D_BLANK;
    if (state != S_IDLE) begin
      n8 = {2'b00, mode_q};
      case (state)
        S_WASH:  n7 = 4'd1;
        S_RINSE: n7 = 4'd2;
        S_SPIN:  n7 = 4'd3;
        default: n7 = 4'd0;
      endcase
      if (state == S_PAUSE) n6 = D_MINUS;
    end
  end

endmodule
